bcd_convert_arbiter: RTL and testbench
======================================

BCD_CONVERT_ARBITER -- requirements
Module: bcd_convert_arbiter

Interface
REQ-001 Parameter N_REQ, default 3: number of requesters sharing the converter.
REQ-002 Parameter WIDTH, default 16: binary operand width.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset, with ports as follows.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- req_i  input  N_REQ  per-requester conversion request, level.
- value_i  input  N_REQ*WIDTH  packed operands; slice k belongs to requester k.
- grant_o  output  N_REQ  one-hot owner of the converter; all zero when idle.
- done_o  output  N_REQ  one-hot, one-cycle result strobe to the owner.
- bcd_o  output  16  four packed BCD digits; digit 0 is in bits [3:0].
- ovf_o  output  1  result exceeded 9999 and was saturated.
- busy_o  output  1  converter occupied (state not IDLE).

Function
REQ-004 FSM states SHALL be IDLE, CONV and DELIVER; the reset state is IDLE.
REQ-005 IDLE with any req_i bit high SHALL, at the accepting edge E0, do the following:
- select the winner by round-robin;
- capture that requester's value_i slice;
- set grant_o to the winner;
- pulse start to the core;
- move to CONV.
REQ-006 Round-robin: the search SHALL start at (last_grant+1) mod N_REQ and take the first set req_i bit; last_grant updates only at an accepting edge.
REQ-007 CONV SHALL run the shift-add-3 algorithm for WIDTH iterations, each iteration being one add-3 cycle then one shift cycle (2*WIDTH = 32 cycles), on a 20-bit (5-digit) BCD accumulator.
REQ-008 The move CONV -> DELIVER SHALL occur at edge E0+2*WIDTH+1 (E33 at default WIDTH).
REQ-009 In DELIVER, done_o SHALL equal grant_o for exactly one cycle (from E33 to E34); bcd_o and ovf_o SHALL update at E33.
REQ-010 DELIVER -> IDLE SHALL occur at E34, clearing grant_o, so the minimum request-to-request spacing is 35 cycles.
REQ-011 If BCD digit 4 is nonzero (value > 9999), bcd_o SHALL be 16'h9999 and ovf_o SHALL be 1; otherwise bcd_o SHALL be the low four digits and ovf_o SHALL be 0.
REQ-012 bcd_o and ovf_o SHALL hold their last result until the next DELIVER.
REQ-013 Changes to value_i after E0 SHALL NOT affect the conversion in progress.
REQ-014 If the owner deasserts req_i during CONV, the conversion SHALL complete and done_o SHALL still pulse.
REQ-015 Requests arriving during CONV or DELIVER SHALL NOT be accepted; they are evaluated in IDLE only.
REQ-016 A requester still holding req_i in IDLE after its own done SHALL be treated as a new request, subject to round-robin.
REQ-017 A value of 0 SHALL produce bcd_o = 16'h0000 and ovf_o = 0 with the same latency as any other value.

Reset
REQ-018 Reset assertion SHALL take effect asynchronously and drive the following:
- state = IDLE;
- grant_o = 0, done_o = 0, busy_o = 0;
- bcd_o = 16'h0000, ovf_o = 0;
- last_grant = N_REQ-1, so requester 0 wins first;
- core accumulator and iteration counter = 0.
REQ-019 Reset asserted mid-CONV SHALL abort the conversion with no done_o pulse; after release, the block SHALL accept pending requests normally.

Structure
REQ-020 Package bcd_pkg SHALL hold the following shared items:
- the FSM state enum;
- the BCD_DIGITS = 5 constant;
- the SAT_BCD = 16'h9999 constant;
- the default N_REQ and WIDTH values.
REQ-021 The shift-add-3 datapath SHALL be the sub-module bin2bcd_core (ports: start, value, done, bcd20), with the arbitration FSM in the top level.

Verification
REQ-022 The bench SHALL cover the following directed scenarios:
- Single request, req_i=001 with value 1234: grant_o=001 at E0; done_o=001 only in cycle E33-E34; bcd_o=16'h1234; ovf_o=0.
- Overflow, value 65535 then 10000: bcd_o=16'h9999 with ovf_o=1 for both; then value 9999 gives 16'h9999 with ovf_o=0.
- Fairness, req_i=111 held continuously after reset: grant order 0,1,2,0, with accepting edges exactly 35 cycles apart.
- Operand stability, value_i changed and owner req_i dropped mid-CONV: result equals the value captured at E0; done_o still pulses.
- Reset at E15 of a conversion: no done_o; all outputs return to reset values; the next request with value 42 yields 16'h0042.
- Zero operand, value 0: bcd_o=16'h0000 with done_o at E33.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD conversion arbiter.
//   state_t    : arbitration FSM states
//   BCD_DIGITS : digits held by the conversion accumulator
//   BCD_W      : accumulator width in bits
//   SAT_BCD    : saturated four-digit result
//   DEF_*      : default parameter values
package bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONV    = 2'd1,
    ST_DELIVER = 2'd2
  } state_t;

  localparam int unsigned BCD_DIGITS = 5;
  localparam int unsigned BCD_W      = 4 * BCD_DIGITS;
  localparam logic [15:0] SAT_BCD    = 16'h9999;
  localparam int unsigned DEF_N_REQ  = 3;
  localparam int unsigned DEF_WIDTH  = 16;

  // One double-dabble correction step on a single digit.
  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

endpackage

// File: rtl/bin2bcd_core.sv
// Sequential shift-add-3 binary to BCD converter.
//   clk, reset : clock, async active-high reset
//   start      : load value and begin (one-cycle pulse)
//   value      : binary operand, sampled with start
//   done       : one-cycle pulse after the last shift
//   bcd20      : five-digit BCD accumulator, holds result after done
module bin2bcd_core
  import bcd_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] value,
  output logic             done,
  output logic [BCD_W-1:0] bcd20
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] shreg;
  logic [CNT_W-1:0] cnt;
  logic             active;
  logic             shift_phase;
  logic [BCD_W-1:0] adj;

  // Add-3 correction applied to every digit in parallel.
  always_comb begin
    adj = bcd20;
    for (int d = 0; d < int'(BCD_DIGITS); d++) begin
      adj[4*d +: 4] = add3(bcd20[4*d +: 4]);
    end
  end

  // Each iteration: one add-3 cycle, then one shift cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg       <= '0;
      cnt         <= '0;
      active      <= 1'b0;
      shift_phase <= 1'b0;
      done        <= 1'b0;
      bcd20       <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        shreg       <= value;
        bcd20       <= '0;
        cnt         <= '0;
        active      <= 1'b1;
        shift_phase <= 1'b0;
      end else if (active) begin
        if (!shift_phase) begin
          bcd20       <= adj;
          shift_phase <= 1'b1;
        end else begin
          {bcd20, shreg} <= {bcd20[BCD_W-2:0], shreg, 1'b0};
          shift_phase    <= 1'b0;
          if (cnt == CNT_W'(WIDTH - 1)) begin
            active <= 1'b0;
            done   <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: rtl/bcd_convert_arbiter.sv
// Round-robin arbiter sharing one binary-to-BCD converter among N_REQ requesters.
//   clk, reset : clock, async active-high reset
//   req_i      : per-requester level request
//   value_i    : packed operands, slice k for requester k
//   grant_o    : one-hot converter owner, zero when idle
//   done_o     : one-hot one-cycle result strobe to the owner
//   bcd_o      : four BCD digits of the last result (saturated)
//   ovf_o      : last result exceeded 9999
//   busy_o     : converter occupied
module bcd_convert_arbiter
  import bcd_pkg::*;
#(
  parameter int unsigned N_REQ = DEF_N_REQ,
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req_i,
  input  logic [N_REQ*WIDTH-1:0] value_i,
  output logic [N_REQ-1:0]       grant_o,
  output logic [N_REQ-1:0]       done_o,
  output logic [15:0]            bcd_o,
  output logic                   ovf_o,
  output logic                   busy_o
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t           state;
  logic [IDX_W-1:0] last_grant;
  logic [IDX_W-1:0] win_idx;
  logic             win_found;
  logic             start_c;
  logic [WIDTH-1:0] win_value;
  logic             core_done;
  logic [BCD_W-1:0] bcd20;

  // Round-robin search starting just after the last winner.
  always_comb begin
    int unsigned cand;
    win_idx   = '0;
    win_found = 1'b0;
    cand      = 0;
    for (int unsigned off = 1; off <= N_REQ; off++) begin
      cand = (32'(last_grant) + off) % N_REQ;
      if (!win_found && req_i[IDX_W'(cand)]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(cand);
      end
    end
  end

  // Core loads the winner's operand on the same edge the grant is taken.
  assign start_c   = (state == ST_IDLE) && win_found;
  assign win_value = value_i[32'(win_idx) * WIDTH +: WIDTH];

  bin2bcd_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk   (clk),
    .reset (reset),
    .start (start_c),
    .value (win_value),
    .done  (core_done),
    .bcd20 (bcd20)
  );

  // Arbitration FSM with registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      last_grant <= IDX_W'(N_REQ - 1);
      grant_o    <= '0;
      done_o     <= '0;
      bcd_o      <= '0;
      ovf_o      <= 1'b0;
      busy_o     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done_o <= '0;
          if (win_found) begin
            grant_o    <= N_REQ'(1) << win_idx;
            last_grant <= win_idx;
            busy_o     <= 1'b1;
            state      <= ST_CONV;
          end
        end
        ST_CONV: begin
          if (core_done) begin
            done_o <= grant_o;
            state  <= ST_DELIVER;
            // Anything in the fifth digit means the value exceeded 9999.
            if (bcd20[BCD_W-1:16] != '0) begin
              bcd_o <= SAT_BCD;
              ovf_o <= 1'b1;
            end else begin
              bcd_o <= bcd20[15:0];
              ovf_o <= 1'b0;
            end
          end
        end
        ST_DELIVER: begin
          done_o  <= '0;
          grant_o <= '0;
          busy_o  <= 1'b0;
          state   <= ST_IDLE;
        end
        default: begin
          state   <= ST_IDLE;
          grant_o <= '0;
          done_o  <= '0;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_convert_arbiter.sv
// Self-checking bench for bcd_convert_arbiter (N_REQ=3, WIDTH=16).
module tb_bcd_convert_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req_i;
  logic [47:0] value_i;
  logic [2:0]  grant_o;
  logic [2:0]  done_o;
  logic [15:0] bcd_o;
  logic        ovf_o;
  logic        busy_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int prev_e0 = 0;
  int last_m = 2;

  typedef struct {
    logic [2:0]  req;
    logic [47:0] vals;
    logic [2:0]  grant;
    logic [15:0] bcd;
    logic        ovf;
  } vec_t;

  vec_t tbl[8];

  bcd_convert_arbiter #(.N_REQ(3), .WIDTH(16)) dut (
    .clk     (clk),
    .reset   (reset),
    .req_i   (req_i),
    .value_i (value_i),
    .grant_o (grant_o),
    .done_o  (done_o),
    .bcd_o   (bcd_o),
    .ovf_o   (ovf_o),
    .busy_o  (busy_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: decimal digits by arithmetic, saturated above 9999.
  function automatic logic [15:0] ref_bcd(input int unsigned v);
    if (v > 9999) return 16'h9999;
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Reference round-robin pick; updates the model's last winner.
  function automatic int rr_pick(input logic [2:0] r);
    for (int off = 1; off <= 3; off++) begin
      int c;
      c = (last_m + off) % 3;
      if (r[2'(c)]) begin
        last_m = c;
        return c;
      end
    end
    return -1;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    req_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset  = 1'b0;
    last_m = 2;
  endtask

  task automatic wait_accept(input string tag, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (grant_o != 3'b000) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s_accept: grant_o stayed 0x%0h, expected a grant", tag, grant_o);
    end
  endtask

  // One full transaction from acceptance (E0) to return to idle (E34).
  task automatic txn(input string tag, input logic [2:0] exp_g, input logic [15:0] exp_b,
                     input logic exp_o, input bit scramble, input bit spacing);
    bit ok;
    bit bad;
    int e0;
    logic [2:0] owner;
    wait_accept(tag, ok);
    if (!ok) return;
    e0 = cyc;
    if (spacing) chk({tag, "_spacing"}, 32'(e0 - prev_e0), 32'd35);
    prev_e0 = e0;
    chk({tag, "_grant"}, 32'(grant_o), 32'(exp_g));
    chk({tag, "_busy"}, 32'(busy_o), 32'd1);
    owner = grant_o;
    bad = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      @(posedge clk);
      #1;
      if (done_o != 3'b000 || grant_o != owner || !busy_o) bad = 1'b1;
      if (scramble && k == 5) begin
        value_i = {$urandom, $urandom};
        req_i   = req_i & ~owner;
      end
    end
    chk({tag, "_hold_e1_e32"}, 32'(bad), 32'd0);
    @(posedge clk);
    #1;
    chk({tag, "_done_e33"}, 32'(done_o), 32'(exp_g));
    chk({tag, "_bcd"}, 32'(bcd_o), 32'(exp_b));
    chk({tag, "_ovf"}, 32'(ovf_o), 32'(exp_o));
    @(posedge clk);
    #1;
    chk({tag, "_idle_e34"}, {29'd0, done_o != 3'b000, grant_o != 3'b000, busy_o}, 32'd0);
    chk({tag, "_bcd_hold"}, 32'(bcd_o), 32'(exp_b));
  endtask

  initial begin
    bit ok;
    bit bad;
    int idx;
    logic [15:0] v;

    tbl[0] = '{3'b001, {16'd0,    16'd0,     16'd1234},  3'b001, 16'h1234, 1'b0};
    tbl[1] = '{3'b001, {16'd0,    16'd0,     16'd65535}, 3'b001, 16'h9999, 1'b1};
    tbl[2] = '{3'b010, {16'd0,    16'd10000, 16'd0},     3'b010, 16'h9999, 1'b1};
    tbl[3] = '{3'b100, {16'd9999, 16'd0,     16'd0},     3'b100, 16'h9999, 1'b0};
    tbl[4] = '{3'b011, {16'd0,    16'd7,     16'd0},     3'b001, 16'h0000, 1'b0};
    tbl[5] = '{3'b011, {16'd0,    16'd807,   16'd5},     3'b010, 16'h0807, 1'b0};
    tbl[6] = '{3'b101, {16'd4095, 16'd0,     16'd100},   3'b100, 16'h4095, 1'b0};
    tbl[7] = '{3'b110, {16'd1,    16'd9990,  16'd0},     3'b010, 16'h9990, 1'b0};

    reset   = 1'b1;
    req_i   = '0;
    value_i = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {16'd0, bcd_o}, 32'd0);
    chk("reset_flags", {26'd0, grant_o, done_o}, 32'd0);
    chk("reset_busy_ovf", {30'd0, busy_o, ovf_o}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_no_req", {28'd0, grant_o, busy_o}, 32'd0);

    // Directed vectors, including overflow bounds and zero.
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      req_i   = tbl[i].req;
      value_i = tbl[i].vals;
      idx     = rr_pick(tbl[i].req);
      txn($sformatf("vec%0d", i), tbl[i].grant, tbl[i].bcd, tbl[i].ovf, 1'b0, 1'b0);
    end

    // Fairness with all requests held from reset.
    do_reset();
    req_i   = 3'b111;
    value_i = {16'd300, 16'd200, 16'd100};
    for (int i = 0; i < 4; i++) begin
      idx = rr_pick(req_i);
      txn($sformatf("fair%0d", i), 3'(1 << idx), ref_bcd(32'(100 * (idx + 1))), 1'b0, 1'b0, i > 0);
    end

    // Operand and request changes mid-conversion.
    req_i   = 3'b010;
    value_i = {16'd0, 16'd3141, 16'd0};
    idx     = rr_pick(req_i);
    txn("stable", 3'b010, 16'h3141, 1'b0, 1'b1, 1'b0);

    // Reset at E15 aborts without a done pulse.
    req_i   = 3'b001;
    value_i = {16'd0, 16'd0, 16'd5555};
    idx     = rr_pick(req_i);
    wait_accept("abort", ok);
    repeat (15) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("abort_grant_busy", {28'd0, grant_o, busy_o}, 32'd0);
    chk("abort_bcd_ovf", {15'd0, bcd_o, ovf_o}, 32'd0);
    bad = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      if (done_o != 3'b000 || grant_o != 3'b000) bad = 1'b1;
    end
    @(negedge clk);
    reset   = 1'b0;
    last_m  = 2;
    value_i = {16'd0, 16'd0, 16'd42};
    idx     = rr_pick(req_i);
    chk("abort_no_done", 32'(bad), 32'd0);
    txn("after_abort", 3'b001, 16'h0042, 1'b0, 1'b0, 1'b0);

    // Randomized transactions against the reference model.
    for (int i = 0; i < 24; i++) begin
      req_i = 3'($urandom_range(1, 7));
      for (int s = 0; s < 3; s++) begin
        v = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(9990, 10010))
                                        : 16'($urandom_range(0, 65535));
        value_i[16*s +: 16] = v;
      end
      idx = rr_pick(req_i);
      v   = 16'(value_i >> (16 * idx));
      txn($sformatf("rnd%0d", i), 3'(1 << idx), ref_bcd(32'(v)), v > 16'd9999,
          $urandom_range(0, 3) == 0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
